aurora_rx_lane_init: RTL and testbench

Per-lane receive initialisation and error-monitor state machine sitting directly downstream of the single-lane Aurora 8B/10B GTP wrapper. It consumes the 2-byte decoded RX word and its status flags, drives comma alignment enables, RX reset and RX polarity back into the transceiver, and declares the lane up. It also produces soft and hard error indications for the channel logic.

---
 rtl/aurora_rx_lane_init.sv | 200 ++++++++++++++++++++
 tb/tb_aurora_rx_lane_init.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_rx_lane_init.sv
// Per-lane Aurora RX initialisation and error monitor.
// Sequences RX reset, comma alignment and polarity recovery for one lane.
// Once the lane is up, errored words are reported as soft errors and tracked
// in a leaky bucket that escalates to a hard error and lane re-initialisation.
module aurora_rx_lane_init #(
    parameter int RST_CYCLES    = 8,
    parameter int COMMA_TARGET  = 4,
    parameter int BAD_LIMIT     = 8,
    parameter int ALIGN_TIMEOUT = 65535,
    parameter int LEAK_PERIOD   = 256,
    parameter int ERR_LIMIT     = 15
) (
    input  logic        USER_CLK,
    input  logic        RESET,
    input  logic [15:0] RX_DATA,
    input  logic [1:0]  RX_CHAR_IS_K,
    input  logic [1:0]  RX_DISP_ERR,
    input  logic [1:0]  RX_NOT_IN_TABLE,
    input  logic        RX_BUF_ERR,
    input  logic        RX_REALIGN,
    input  logic        RESET_LISM,
    output logic        RX_RESET,
    output logic        ENMCOMMAALIGN,
    output logic        ENPCOMMAALIGN,
    output logic        RX_POLARITY,
    output logic        LANE_UP,
    output logic        SOFT_ERR,
    output logic        HARD_ERR
);

    // Each counter only needs to hold its terminal value minus one: the
    // transition fires on the cycle that would have reached the limit.
    localparam int RST_W   = ($clog2(RST_CYCLES)    < 1) ? 1 : $clog2(RST_CYCLES);
    localparam int COMMA_W = ($clog2(COMMA_TARGET)  < 1) ? 1 : $clog2(COMMA_TARGET);
    localparam int BAD_W   = ($clog2(BAD_LIMIT)     < 1) ? 1 : $clog2(BAD_LIMIT);
    localparam int TO_W    = ($clog2(ALIGN_TIMEOUT) < 1) ? 1 : $clog2(ALIGN_TIMEOUT);
    localparam int LEAK_W  = ($clog2(LEAK_PERIOD)   < 1) ? 1 : $clog2(LEAK_PERIOD);

    localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(RST_CYCLES - 1);
    localparam logic [COMMA_W-1:0] COMMA_LAST = COMMA_W'(COMMA_TARGET - 1);
    localparam logic [BAD_W-1:0]   BAD_LAST   = BAD_W'(BAD_LIMIT - 1);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(ALIGN_TIMEOUT - 1);
    localparam logic [LEAK_W-1:0]  LEAK_LAST  = LEAK_W'(LEAK_PERIOD - 1);
    localparam logic [3:0]         ERR_LIM    = 4'(ERR_LIMIT);

    typedef enum logic [1:0] {
        ST_RST,
        ST_ALIGN,
        ST_READY
    } state_t;

    state_t             state, state_next;
    logic [RST_W-1:0]   rst_cnt, rst_cnt_next;
    logic [COMMA_W-1:0] comma_cnt, comma_next;
    logic [BAD_W-1:0]   bad_cnt, bad_next;
    logic [TO_W-1:0]    to_cnt, to_next;
    logic [LEAK_W-1:0]  leak_cnt, leak_next;
    logic [3:0]         bucket, bucket_next;
    logic               soft_next, hard_next, pol_toggle;

    logic err_word, comma_word, comma_hit, bad_hit, leak_wrap;
    logic unused_bits;

    assign err_word   = |(RX_DISP_ERR | RX_NOT_IN_TABLE);
    assign comma_word = RX_CHAR_IS_K[1] && (RX_DATA[15:8] == 8'hBC) && !err_word;
    assign comma_hit  = comma_word && !RX_REALIGN && (comma_cnt == COMMA_LAST);
    assign bad_hit    = err_word && (bad_cnt == BAD_LAST);
    assign leak_wrap  = (leak_cnt == LEAK_LAST);

    // Second byte and its K flag play no part in lane initialisation.
    assign unused_bits = ^{RX_DATA[7:0], RX_CHAR_IS_K[0]};

    // Next-state, counter and event decode.
    always_comb begin
        state_next   = state;
        rst_cnt_next = '0;
        comma_next   = '0;
        bad_next     = '0;
        to_next      = '0;
        leak_next    = '0;
        bucket_next  = '0;
        soft_next    = 1'b0;
        hard_next    = 1'b0;
        pol_toggle   = 1'b0;

        case (state)
            ST_RST: begin
                if (rst_cnt == RST_LAST) begin
                    state_next = ST_ALIGN;
                end else begin
                    rst_cnt_next = rst_cnt + 1'b1;
                end
            end

            ST_ALIGN: begin
                if (err_word || RX_REALIGN) begin
                    comma_next = '0;
                end else if (comma_word) begin
                    comma_next = comma_cnt + 1'b1;
                end else begin
                    comma_next = comma_cnt;
                end
                bad_next = err_word ? bad_cnt + 1'b1 : '0;
                to_next  = to_cnt + 1'b1;

                if (RESET_LISM) begin
                    state_next = ST_RST;
                end else if (comma_hit) begin
                    state_next = ST_READY;
                end else if (bad_hit) begin
                    pol_toggle = 1'b1;
                    state_next = ST_RST;
                end else if (to_cnt == TO_LAST) begin
                    state_next = ST_RST;
                end
            end

            ST_READY: begin
                soft_next = err_word;
                leak_next = leak_wrap ? '0 : leak_cnt + 1'b1;

                // A leak tick and a new error cancel each other out.
                if (err_word && leak_wrap) begin
                    bucket_next = bucket;
                end else if (err_word) begin
                    bucket_next = (bucket == 4'hF) ? bucket : bucket + 1'b1;
                end else if (leak_wrap) begin
                    bucket_next = (bucket == 4'h0) ? bucket : bucket - 1'b1;
                end else begin
                    bucket_next = bucket;
                end

                if (RESET_LISM) begin
                    state_next = ST_RST;
                end else if (RX_BUF_ERR || (bucket_next >= ERR_LIM)) begin
                    hard_next  = 1'b1;
                    state_next = ST_RST;
                end
            end

            default: state_next = ST_RST;
        endcase

        // Per-state counters only survive while the FSM stays in that state.
        if (state_next != ST_ALIGN) begin
            comma_next = '0;
            bad_next   = '0;
            to_next    = '0;
        end
        if (state_next != ST_READY) begin
            leak_next   = '0;
            bucket_next = '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge USER_CLK) begin
        if (RESET) begin
            state     <= ST_RST;
            rst_cnt   <= '0;
            comma_cnt <= '0;
            bad_cnt   <= '0;
            to_cnt    <= '0;
            leak_cnt  <= '0;
            bucket    <= '0;
        end else begin
            state     <= state_next;
            rst_cnt   <= rst_cnt_next;
            comma_cnt <= comma_next;
            bad_cnt   <= bad_next;
            to_cnt    <= to_next;
            leak_cnt  <= leak_next;
            bucket    <= bucket_next;
        end
    end

    // Outputs are registered from the next state so they change with it.
    always_ff @(posedge USER_CLK) begin
        if (RESET) begin
            RX_RESET      <= 1'b1;
            ENMCOMMAALIGN <= 1'b0;
            ENPCOMMAALIGN <= 1'b0;
            RX_POLARITY   <= 1'b0;
            LANE_UP       <= 1'b0;
            SOFT_ERR      <= 1'b0;
            HARD_ERR      <= 1'b0;
        end else begin
            RX_RESET      <= (state_next == ST_RST);
            ENMCOMMAALIGN <= (state_next == ST_ALIGN);
            ENPCOMMAALIGN <= (state_next == ST_ALIGN);
            LANE_UP       <= (state_next == ST_READY);
            SOFT_ERR      <= soft_next;
            HARD_ERR      <= hard_next;
            if (pol_toggle) begin
                RX_POLARITY <= ~RX_POLARITY;
            end
        end
    end

endmodule

// File: tb/tb_aurora_rx_lane_init.sv
// Self-checking bench for aurora_rx_lane_init: directed phases with random
// word contents, compared every cycle against a behavioural lane model.
module tb_aurora_rx_lane_init;

    localparam int RST_CYCLES    = 8;
    localparam int COMMA_TARGET  = 4;
    localparam int BAD_LIMIT     = 8;
    localparam int ALIGN_TIMEOUT = 200;
    localparam int LEAK_PERIOD   = 256;
    localparam int ERR_LIMIT     = 15;

    logic        USER_CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] RX_DATA = '0;
    logic [1:0]  RX_CHAR_IS_K = '0;
    logic [1:0]  RX_DISP_ERR = '0;
    logic [1:0]  RX_NOT_IN_TABLE = '0;
    logic        RX_BUF_ERR = 1'b0;
    logic        RX_REALIGN = 1'b0;
    logic        RESET_LISM = 1'b0;
    logic        RX_RESET, ENMCOMMAALIGN, ENPCOMMAALIGN, RX_POLARITY;
    logic        LANE_UP, SOFT_ERR, HARD_ERR;

    always #5 USER_CLK = ~USER_CLK;

    aurora_rx_lane_init #(
        .RST_CYCLES    (RST_CYCLES),
        .COMMA_TARGET  (COMMA_TARGET),
        .BAD_LIMIT     (BAD_LIMIT),
        .ALIGN_TIMEOUT (ALIGN_TIMEOUT),
        .LEAK_PERIOD   (LEAK_PERIOD),
        .ERR_LIMIT     (ERR_LIMIT)
    ) dut (
        .USER_CLK        (USER_CLK),
        .RESET           (RESET),
        .RX_DATA         (RX_DATA),
        .RX_CHAR_IS_K    (RX_CHAR_IS_K),
        .RX_DISP_ERR     (RX_DISP_ERR),
        .RX_NOT_IN_TABLE (RX_NOT_IN_TABLE),
        .RX_BUF_ERR      (RX_BUF_ERR),
        .RX_REALIGN      (RX_REALIGN),
        .RESET_LISM      (RESET_LISM),
        .RX_RESET        (RX_RESET),
        .ENMCOMMAALIGN   (ENMCOMMAALIGN),
        .ENPCOMMAALIGN   (ENPCOMMAALIGN),
        .RX_POLARITY     (RX_POLARITY),
        .LANE_UP         (LANE_UP),
        .SOFT_ERR        (SOFT_ERR),
        .HARD_ERR        (HARD_ERR)
    );

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Behavioural lane model: phase name plus elapsed-cycle counts.
    string m_mode = "RST";
    int    m_rst_age, m_align_age, m_ready_age, m_commas, m_bad, m_bucket;
    bit    m_pol = 1'b0;
    bit    e_rx_reset = 1'b1, e_en = 1'b0, e_up = 1'b0, e_soft = 1'b0, e_hard = 1'b0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic m_enter_rst();
        m_mode      = "RST";
        m_rst_age   = 0;
        m_align_age = 0;
        m_ready_age = 0;
        m_commas    = 0;
        m_bad       = 0;
        m_bucket    = 0;
    endtask

    task automatic model_step();
        bit err, comma, wrap;
        err    = |(RX_DISP_ERR | RX_NOT_IN_TABLE);
        comma  = RX_CHAR_IS_K[1] && (RX_DATA[15:8] == 8'hBC) && !err;
        e_soft = 1'b0;
        e_hard = 1'b0;
        if (RESET) begin
            m_enter_rst();
            m_pol = 1'b0;
        end else if (m_mode == "RST") begin
            m_rst_age++;
            if (m_rst_age == RST_CYCLES) begin
                m_mode = "ALIGN";
                m_align_age = 0;
                m_commas = 0;
                m_bad = 0;
            end
        end else if (m_mode == "ALIGN") begin
            m_align_age++;
            if (err || RX_REALIGN) m_commas = 0;
            else if (comma) m_commas++;
            m_bad = err ? m_bad + 1 : 0;
            if (RESET_LISM) m_enter_rst();
            else if (m_commas == COMMA_TARGET) begin
                m_mode = "READY";
                m_ready_age = 0;
                m_bucket = 0;
            end else if (m_bad == BAD_LIMIT) begin
                m_pol = !m_pol;
                m_enter_rst();
            end else if (m_align_age == ALIGN_TIMEOUT) m_enter_rst();
        end else begin
            m_ready_age++;
            wrap   = (m_ready_age % LEAK_PERIOD) == 0;
            e_soft = err;
            if (err && !wrap) m_bucket = (m_bucket < 15) ? m_bucket + 1 : 15;
            else if (wrap && !err) m_bucket = (m_bucket > 0) ? m_bucket - 1 : 0;
            if (RESET_LISM) m_enter_rst();
            else if (RX_BUF_ERR || m_bucket >= ERR_LIMIT) begin
                e_hard = 1'b1;
                m_enter_rst();
            end
        end
        e_rx_reset = (m_mode == "RST");
        e_en       = (m_mode == "ALIGN");
        e_up       = (m_mode == "READY");
    endtask

    task automatic check_all();
        chk("RX_RESET", RX_RESET, e_rx_reset);
        chk("ENMCOMMAALIGN", ENMCOMMAALIGN, e_en);
        chk("ENPCOMMAALIGN", ENPCOMMAALIGN, e_en);
        chk("LANE_UP", LANE_UP, e_up);
        chk("SOFT_ERR", SOFT_ERR, e_soft);
        chk("HARD_ERR", HARD_ERR, e_hard);
        chk("RX_POLARITY", RX_POLARITY, m_pol);
    endtask

    task automatic tick();
        @(posedge USER_CLK);
        model_step();
        #1;
        check_all();
    endtask

    // kind: 0 comma, 1 clean non-comma, 2 random errored, 3 both bytes not-in-table
    task automatic drive(input int kind);
        logic [7:0] hi;
        RX_DISP_ERR = '0;
        RX_NOT_IN_TABLE = '0;
        RX_BUF_ERR = 1'b0;
        RX_REALIGN = 1'b0;
        RESET_LISM = 1'b0;
        case (kind)
            0: begin
                RX_DATA = {8'hBC, 8'($urandom)};
                RX_CHAR_IS_K = {1'b1, 1'($urandom)};
            end
            1: begin
                hi = 8'($urandom);
                if (hi == 8'hBC) hi = 8'h50;
                RX_DATA = {hi, 8'($urandom)};
                RX_CHAR_IS_K = 2'($urandom);
            end
            2: begin
                RX_DATA = 16'($urandom);
                RX_CHAR_IS_K = 2'($urandom);
                RX_DISP_ERR = 2'($urandom);
                RX_NOT_IN_TABLE = 2'($urandom);
                if ((RX_DISP_ERR | RX_NOT_IN_TABLE) == 2'b00) RX_NOT_IN_TABLE = 2'b01;
            end
            default: begin
                RX_DATA = 16'($urandom);
                RX_CHAR_IS_K = 2'($urandom);
                RX_NOT_IN_TABLE = 2'b11;
            end
        endcase
    endtask

    task automatic run_commas_until_ready();
        int n = 0;
        while (m_mode != "READY" && n < 100) begin
            drive(0);
            tick();
            n++;
        end
        chk("reach_ready", LANE_UP, 1'b1);
    endtask

    task automatic flip_polarity();
        int n = 0;
        while (m_mode == "RST" && n < 50) begin
            drive(3);
            tick();
            n++;
        end
        for (int i = 0; i < BAD_LIMIT; i++) begin
            drive(3);
            tick();
        end
    endtask

    initial begin
        int first_en, first_up, hi_cnt, sc, hard_at, hc, n, r;
        logic up_at_hard, rr_at_hard, en_before;

        // Reset held: reset values
        drive(0);
        RESET = 1'b1;
        repeat (3) tick();

        // Release with clean commas
        RESET = 1'b0;
        first_en = -1;
        first_up = -1;
        for (int i = 1; i <= 20; i++) begin
            drive(0);
            tick();
            if (first_en < 0 && ENMCOMMAALIGN) first_en = i;
            if (first_up < 0 && LANE_UP) first_up = i;
        end
        chk_int("align_en_edge", first_en, RST_CYCLES);
        chk_int("lane_up_edge", first_up, RST_CYCLES + COMMA_TARGET);

        // Electrical-idle reset request in READY
        drive(0);
        RESET_LISM = 1'b1;
        tick();
        chk("lism_no_hard", HARD_ERR, 1'b0);
        chk("lism_lane_down", LANE_UP, 1'b0);
        chk("lism_rx_reset", RX_RESET, 1'b1);

        // Bad words in ALIGN flip polarity and restart
        flip_polarity();
        chk("pol_flip", RX_POLARITY, 1'b1);
        chk("pol_flip_rx_reset", RX_RESET, 1'b1);
        hi_cnt = 1;
        for (int i = 0; i < 20; i++) begin
            drive(0);
            tick();
            if (RX_RESET) hi_cnt++;
            else break;
        end
        chk_int("rst_pulse_len", hi_cnt, RST_CYCLES);
        run_commas_until_ready();
        chk("pol_kept", RX_POLARITY, 1'b1);

        // Three isolated errored words, then drain the bucket
        sc = 0;
        for (int k = 0; k < 3; k++) begin
            drive(2);
            tick();
            if (SOFT_ERR) sc++;
            drive(1);
            tick();
            if (SOFT_ERR) sc++;
            tick();
            if (SOFT_ERR) sc++;
        end
        drive(0);
        tick();
        if (SOFT_ERR) sc++;
        chk_int("isolated_soft_pulses", sc, 3);
        for (int i = 0; i < 3 * LEAK_PERIOD; i++) begin
            drive(($urandom % 2 == 0) ? 0 : 1);
            tick();
        end

        // Error on a leak-wrap cycle leaves the bucket unchanged
        n = 0;
        while (((m_ready_age + 1) % LEAK_PERIOD) != 0 && n < 300) begin
            drive(1);
            tick();
            n++;
        end
        drive(2);
        tick();

        // Fifteen consecutive errored words
        sc = 0;
        hard_at = -1;
        up_at_hard = 1'b1;
        rr_at_hard = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            drive(2);
            tick();
            if (SOFT_ERR) sc++;
            if (HARD_ERR && hard_at < 0) begin
                hard_at = i;
                up_at_hard = LANE_UP;
                rr_at_hard = RX_RESET;
            end
        end
        chk_int("burst_soft_pulses", sc, 15);
        chk_int("burst_hard_cycle", hard_at, 15);
        chk("burst_lane_down", up_at_hard, 1'b0);
        chk("burst_rx_reset", rr_at_hard, 1'b1);
        run_commas_until_ready();

        // Elastic buffer error in READY
        drive(0);
        RX_BUF_ERR = 1'b1;
        tick();
        hc = HARD_ERR ? 1 : 0;
        chk("buf_err_rx_reset", RX_RESET, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(0);
            tick();
            if (HARD_ERR) hc++;
        end
        chk_int("buf_err_hard_pulses", hc, 1);
        run_commas_until_ready();

        // Alignment timeout with clean non-comma words
        drive(0);
        RESET_LISM = 1'b1;
        tick();
        n = 0;
        while (m_mode == "RST" && n < 50) begin
            drive(1);
            tick();
            n++;
        end
        en_before = 1'b0;
        for (int i = 1; i <= ALIGN_TIMEOUT; i++) begin
            drive(1);
            tick();
            if (i == ALIGN_TIMEOUT - 1) en_before = ENMCOMMAALIGN;
        end
        chk("timeout_align_held", en_before, 1'b1);
        chk("timeout_rx_reset", RX_RESET, 1'b1);

        // Randomised traffic across all states
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55) drive(0);
            else if (r < 75) drive(1);
            else if (r < 92) drive(2);
            else drive(3);
            RX_REALIGN = ($urandom_range(0, 99) < 4);
            RESET_LISM = ($urandom_range(0, 199) < 1);
            RX_BUF_ERR = ($urandom_range(0, 199) < 1);
            tick();
        end

        // RESET in READY with inverted polarity
        if (!m_pol) flip_polarity();
        run_commas_until_ready();
        chk("pre_reset_pol", RX_POLARITY, 1'b1);
        drive(0);
        RESET = 1'b1;
        tick();
        chk("reset_pol", RX_POLARITY, 1'b0);
        chk("reset_rx_reset", RX_RESET, 1'b1);
        chk("reset_lane_up", LANE_UP, 1'b0);
        chk("reset_align_en", ENMCOMMAALIGN, 1'b0);
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
